// File: rtl/adc_burst_buffer.sv
// First-word-fall-through burst FIFO between ADC acquisition and the DDR3 writer, with fill framing checks.
// Optional per-fill XOR checksum is built only when ADC_BURST_BUF_CHECKSUM_EN is defined.
module adc_burst_buffer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int BURST_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [127:0]          in_dat,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic                  in_eof,
  output logic [127:0]          out_dat,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  burst_avail,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic                  framing_err,
  output logic [23:0]           fill_words,
  output logic                  fill_done,
  output logic [31:0]           checksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] BURST_L = (ADDR_WIDTH + 1)'(BURST_WORDS);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

  typedef enum logic {IDLE, IN_FILL} fill_state_t;

  logic [129:0]          mem [DEPTH];
  logic [129:0]          head;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_next;
  logic [ADDR_WIDTH:0]   eof_cnt, level_next;
  logic                  wr_en, pop, drop;
  fill_state_t           state, state_nx;
  logic [23:0]           cnt, cnt_nx, cnt_inc, fill_words_nx;
  logic                  fill_done_nx, ferr_nx;

  assign full        = (level == DEPTH_L);
  assign out_valid   = (level != '0);
  assign burst_avail = (level >= BURST_L) || (eof_cnt != '0);
  assign wr_en       = in_valid && !full && !flush;
  assign drop        = in_valid && full && !flush;
  assign pop         = out_valid && out_ready && !flush;
  assign rd_next     = pop ? rd_ptr + PTR_ONE : rd_ptr;
  assign out_dat     = head[127:0];
  assign out_sof     = head[128];
  assign out_eof     = head[129];

  always_comb begin
    level_next = level;
    if (wr_en && !pop)
      level_next = level + ONE_L;
    else if (pop && !wr_en)
      level_next = level - ONE_L;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {in_eof, in_sof, in_dat};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      eof_cnt  <= '0;
      head     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      eof_cnt  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_next;
      level  <= level_next;
      if ((wr_en && in_eof) && !(pop && out_eof))
        eof_cnt <= eof_cnt + ONE_L;
      else if ((pop && out_eof) && !(wr_en && in_eof))
        eof_cnt <= eof_cnt - ONE_L;
      // The incoming word bypasses the array when it becomes the only stored entry.
      if (level_next != '0)
        head <= (wr_en && (wr_ptr == rd_next)) ? {in_eof, in_sof, in_dat} : mem[rd_next];
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fill_words  <= '0;
      fill_done   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      fill_words  <= fill_words_nx;
      fill_done   <= fill_done_nx;
      framing_err <= ferr_nx;
    end
  end

  assign cnt_inc = (cnt == 24'hFFFFFF) ? cnt : cnt + 24'd1;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    fill_words_nx = fill_words;
    fill_done_nx  = 1'b0;
    ferr_nx       = framing_err;
    if (flush) begin
      state_nx      = IDLE;
      cnt_nx        = '0;
      fill_words_nx = '0;
      ferr_nx       = 1'b0;
    end else if (wr_en) begin
      if (in_sof) begin
        if (state == IN_FILL)
          ferr_nx = 1'b1;
        if (in_eof) begin
          fill_words_nx = 24'd1;
          fill_done_nx  = 1'b1;
          state_nx      = IDLE;
          cnt_nx        = '0;
        end else begin
          state_nx = IN_FILL;
          cnt_nx   = 24'd1;
        end
      end else if (state == IN_FILL) begin
        cnt_nx = cnt_inc;
        if (in_eof) begin
          fill_words_nx = cnt_inc;
          fill_done_nx  = 1'b1;
          state_nx      = IDLE;
        end
      end else if (in_eof) begin
        ferr_nx = 1'b1;
      end
    end
  end

`ifdef ADC_BURST_BUF_CHECKSUM_EN
  logic [31:0] acc, acc_x;

  assign acc_x = acc ^ in_dat[127:96] ^ in_dat[95:64] ^ in_dat[63:32] ^ in_dat[31:0];

  // Header words reset the accumulator and never contribute to it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      checksum <= '0;
    end else if (flush) begin
      acc      <= '0;
      checksum <= '0;
    end else if (wr_en) begin
      if (in_sof) begin
        acc <= '0;
        if (in_eof)
          checksum <= '0;
      end else if (state == IN_FILL) begin
        acc <= acc_x;
        if (in_eof)
          checksum <= acc_x;
      end
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
